// File: rtl/station_pkg.sv
// Station map constants, coordinate table and player state encoding.
// Shared by the route player and its coordinate lookup.
package station_pkg;

  localparam int N_STATIONS = 46;

  typedef logic [5:0]  station_idx_t;
  typedef logic [19:0] station_xy_t;

  typedef enum logic [1:0] {
    LOAD,
    LOADED,
    PLAY
  } state_t;

  // {x[9:0], y[9:0]} marker pixel per station index
  localparam station_xy_t STATION_XY [N_STATIONS] = '{
    {10'd571, 10'd97 }, {10'd520, 10'd130}, {10'd495, 10'd158},
    {10'd465, 10'd186}, {10'd452, 10'd196}, {10'd430, 10'd215},
    {10'd410, 10'd205}, {10'd530, 10'd301}, {10'd505, 10'd295},
    {10'd520, 10'd312}, {10'd480, 10'd300}, {10'd440, 10'd300},
    {10'd420, 10'd340}, {10'd470, 10'd345}, {10'd500, 10'd370},
    {10'd426, 10'd407}, {10'd440, 10'd415}, {10'd380, 10'd410},
    {10'd320, 10'd390}, {10'd350, 10'd360}, {10'd330, 10'd320},
    {10'd300, 10'd310}, {10'd370, 10'd270}, {10'd320, 10'd250},
    {10'd300, 10'd230}, {10'd340, 10'd215}, {10'd400, 10'd180},
    {10'd430, 10'd250}, {10'd480, 10'd240}, {10'd500, 10'd230},
    {10'd230, 10'd330}, {10'd390, 10'd430}, {10'd485, 10'd390},
    {10'd160, 10'd107}, {10'd220, 10'd150}, {10'd280, 10'd200},
    {10'd550, 10'd80 }, {10'd590, 10'd110}, {10'd500, 10'd180},
    {10'd450, 10'd230}, {10'd460, 10'd270}, {10'd395, 10'd370},
    {10'd345, 10'd280}, {10'd410, 10'd320}, {10'd480, 10'd330},
    {10'd478, 10'd219}
  };

endpackage

// File: rtl/station_coord_rom.sv
// Registered station index to marker pixel lookup.
// Output holds between reads; out-of-range indices give (0,0).
module station_coord_rom
  import station_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [9:0]       x,
  output logic [9:0]       y
);

  station_xy_t xy_q;

  // one-cycle lookup, held until the next enabled read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      xy_q <= '0;
    end else if (en) begin
      if (int'(idx) < N_STATIONS) xy_q <= STATION_XY[idx];
      else xy_q <= '0;
    end
  end

  assign x = xy_q[19:10];
  assign y = xy_q[9:0];

endmodule

// File: rtl/path_station_player.sv
// Stores a route of station indices and replays it as marker
// coordinates, one node per HOLD_FRAMES frames.
module path_station_player #(
  parameter int DEPTH       = 64,
  parameter int IDX_W       = 6,
  parameter int N_STATIONS  = 46,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic                       path_valid,
  input  logic [IDX_W-1:0]           path_idx,
  input  logic                       path_last,
  output logic                       path_ready,
  input  logic                       play,
  input  logic                       clear,
  output logic                       busy,
  output logic                       done,
  output logic                       marker_valid,
  output logic [9:0]                 pos_x_out,
  output logic [9:0]                 pos_y_out,
  output logic [$clog2(DEPTH):0]     node_count,
  output logic                       overflow,
  output logic                       bad_idx
);
  import station_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t           state, nxt;
  logic [CW-1:0]    count;
  logic [AW-1:0]    ptr;
  logic [HW-1:0]    hold;
  logic             rd_req;
  logic [IDX_W-1:0] mem [DEPTH];

  logic beat, idx_ok, full, more;
  logic play_tick, tick_end;
  logic go, adv, fin;

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= LOAD;
    else state <= nxt;
  end

  // next state and per-cycle control decode
  always_comb begin
    nxt       = state;
    go        = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    beat      = (state == LOAD) && path_ready && path_valid;
    idx_ok    = int'(path_idx) < N_STATIONS;
    full      = count == CW'(DEPTH);
    more      = ({1'b0, ptr} + CW'(1)) < count;
    play_tick = (state == PLAY) && !rd_req && frame_tick;
    tick_end  = play_tick && (hold == HW'(HOLD_FRAMES - 1));
    if (clear) begin
      nxt = LOAD;
    end else begin
      unique case (state)
        LOAD: begin
          if (beat && path_last) nxt = LOADED;
        end
        LOADED: begin
          if (play) begin
            if (count != '0) begin
              nxt = PLAY;
              go  = 1'b1;
            end else begin
              fin = 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick_end) begin
            if (more) begin
              adv = 1'b1;
            end else begin
              fin = 1'b1;
              nxt = LOADED;
            end
          end
        end
        default: nxt = LOAD;
      endcase
    end
  end

  // route storage, written in beat order
  always_ff @(posedge Clk) begin
    if (beat && !clear && idx_ok && !full)
      mem[count[AW-1:0]] <= path_idx;
  end

  // counters, pointer, hold timer and sticky flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count        <= '0;
      ptr          <= '0;
      hold         <= '0;
      rd_req       <= 1'b0;
      marker_valid <= 1'b0;
      overflow     <= 1'b0;
      bad_idx      <= 1'b0;
      done         <= 1'b0;
      path_ready   <= 1'b0;
    end else if (clear) begin
      count        <= '0;
      ptr          <= '0;
      hold         <= '0;
      rd_req       <= 1'b0;
      marker_valid <= 1'b0;
      overflow     <= 1'b0;
      bad_idx      <= 1'b0;
      done         <= 1'b0;
      path_ready   <= 1'b1;
    end else begin
      path_ready <= (nxt == LOAD);
      done       <= fin;
      if (beat) begin
        unique case (1'b1)
          !idx_ok:         bad_idx  <= 1'b1;
          idx_ok && full:  overflow <= 1'b1;
          idx_ok && !full: count    <= count + CW'(1);
        endcase
      end
      if (go) begin
        ptr    <= '0;
        rd_req <= 1'b1;
      end else if (rd_req) begin
        rd_req       <= 1'b0;
        marker_valid <= 1'b1;
        hold         <= '0;
      end else if (adv) begin
        ptr    <= ptr + AW'(1);
        rd_req <= 1'b1;
        hold   <= '0;
      end else if (play_tick && !tick_end) begin
        hold <= hold + HW'(1);
      end
    end
  end

  station_coord_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      (rd_req && !clear),
    .idx     (mem[ptr]),
    .x       (pos_x_out),
    .y       (pos_y_out)
  );

  assign busy       = (state == PLAY);
  assign node_count = count;

endmodule

// File: tb/tb_path_station_player.sv
// Randomized route load/playback bench for path_station_player.
// Small player (DEPTH 4, 2-frame hold) against a timeline model.
module tb_path_station_player;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          path_valid = 1'b0;
  logic [5:0]    path_idx = '0;
  logic          path_last = 1'b0;
  logic          path_ready;
  logic          play = 1'b0;
  logic          clear = 1'b0;
  logic          busy, done, marker_valid;
  logic [9:0]    pos_x_out, pos_y_out;
  logic [CW-1:0] node_count;
  logic          overflow, bad_idx;

  path_station_player #(
    .DEPTH       (DEPTH),
    .IDX_W       (6),
    .N_STATIONS  (46),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .path_valid   (path_valid),
    .path_idx     (path_idx),
    .path_last    (path_last),
    .path_ready   (path_ready),
    .play         (play),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .marker_valid (marker_valid),
    .pos_x_out    (pos_x_out),
    .pos_y_out    (pos_y_out),
    .node_count   (node_count),
    .overflow     (overflow),
    .bad_idx      (bad_idx)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  int  route[$];
  int  mq[$];
  bit  m_ovf, m_bad, exp_mv;
  int  exp_x, exp_y;
  int  pool[6] = '{0, 3, 7, 15, 33, 45};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_x(input int idx);
    case (idx)
      0: return 571;
      3: return 465;
      7: return 530;
      15: return 426;
      33: return 160;
      45: return 478;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_y(input int idx);
    case (idx)
      0: return 97;
      3: return 186;
      7: return 301;
      15: return 407;
      33: return 107;
      45: return 219;
      default: return 0;
    endcase
  endfunction

  function automatic int pick();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(46, 63));
    return pool[$urandom_range(0, 5)];
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_bad  = 1'b0;
    exp_mv = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    check("clr_ready", path_ready, 1);
    check("clr_count", node_count, 0);
    check("clr_mv", marker_valid, 0);
    check("clr_flags", {overflow, bad_idx}, 0);
    check("clr_busy", busy, 0);
  endtask

  task automatic load_route();
    for (int i = 0; i < route.size(); i++) begin
      path_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      path_valid = 1'b1;
      path_idx   = 6'(route[i]);
      path_last  = (i == route.size() - 1);
      step();
      if (route[i] >= 46) m_bad = 1'b1;
      else if (mq.size() >= DEPTH) m_ovf = 1'b1;
      else mq.push_back(route[i]);
    end
    path_valid = 1'b0;
    path_last  = 1'b0;
    check("ld_ready", path_ready, 0);
    check("ld_count", node_count, mq.size());
    check("ld_ovf", overflow, m_ovf);
    check("ld_bad", bad_idx, m_bad);
    check("ld_busy", busy, 0);
  endtask

  // each node shows 2 cycles after its trigger, holds for HOLD ticks
  // seen from its first visible cycle; done follows the last hold
  task automatic run_play(input int pct);
    int n, k, next_k, show_at, ticks, done_at;
    bit holding, fin, ft;
    n = mq.size();
    play = 1'b1;
    step();
    play = 1'b0;
    if (n == 0) begin
      check("empty_done", done, 1);
      check("empty_busy", busy, 0);
      check("empty_mv", marker_valid, exp_mv);
      step();
      check("empty_done_drop", done, 0);
      return;
    end
    k = 0; next_k = 0; show_at = 2; ticks = 0; done_at = -1;
    holding = 1'b0; fin = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (c == show_at) begin
        k = next_k;
        exp_mv = 1'b1;
        exp_x = ref_x(mq[k]);
        exp_y = ref_y(mq[k]);
        holding = 1'b1;
        ticks = 0;
      end
      check("mv", marker_valid, exp_mv);
      if (exp_mv) begin
        check("pos_x", pos_x_out, exp_x);
        check("pos_y", pos_y_out, exp_y);
      end
      check("busy", busy, (done_at < 0) || (c < done_at));
      check("done", done, c == done_at);
      if (done_at >= 0 && c == done_at + 1) begin
        fin = 1'b1;
        break;
      end
      ft = ($urandom_range(0, 99) < pct);
      frame_tick = ft;
      if (holding && ft) begin
        ticks++;
        if (ticks == HOLD) begin
          holding = 1'b0;
          if (k < n - 1) begin
            next_k = k + 1;
            show_at = c + 2;
          end else begin
            done_at = c + 1;
          end
        end
      end
      step();
    end
    frame_tick = 1'b0;
    if (!fin) check("play_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", path_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mv", marker_valid, 0);
    check("rst_pos", {pos_x_out, pos_y_out}, 0);
    check("rst_count", node_count, 0);
    check("rst_flags", {overflow, bad_idx}, 0);
    Reset_n = 1'b1;
    step();
    check("rel_ready", path_ready, 1);

    route = '{3, 7, 15};
    load_route();
    run_play(40);
    run_play(100);

    play = 1'b1;
    step();
    play = 1'b0;
    step();
    step();
    check("pre_clr_mv", marker_valid, 1);
    clear = 1'b1;
    play  = 1'b1;
    step();
    clear = 1'b0;
    play  = 1'b0;
    model_reset();
    check("cp_mv", marker_valid, 0);
    check("cp_count", node_count, 0);
    check("cp_done", done, 0);
    check("cp_busy", busy, 0);
    check("cp_ready", path_ready, 1);
    step();
    check("cp_done2", done, 0);

    route = '{0, 3, 7, 15, 33, 45};
    load_route();
    check("ovf_count", node_count, 4);
    check("ovf_flag", overflow, 1);
    run_play(50);

    do_clear();
    route = '{50, 0};
    load_route();
    check("bad_flag", bad_idx, 1);
    check("bad_count", node_count, 1);
    run_play(50);
    check("bad_x", pos_x_out, 571);
    check("bad_y", pos_y_out, 97);

    do_clear();
    route = '{46};
    load_route();
    check("only_bad_count", node_count, 0);
    run_play(50);

    do_clear();
    route = '{45, 33};
    load_route();
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (3) step();
    check("mid_busy", busy, 1);
    #3 Reset_n = 1'b0;
    #1;
    check("ar_ready", path_ready, 0);
    check("ar_busy", busy, 0);
    check("ar_mv", marker_valid, 0);
    check("ar_pos", {pos_x_out, pos_y_out}, 0);
    check("ar_count", node_count, 0);
    check("ar_flags", {overflow, bad_idx, done}, 0);
    model_reset();
    #2 Reset_n = 1'b1;
    #1;
    check("ar_ready_rel", path_ready, 0);
    step();
    check("ar_ready_clk", path_ready, 1);

    for (int r = 0; r < 30; r++) begin
      do_clear();
      route.delete();
      repeat ($urandom_range(1, 6)) route.push_back(pick());
      load_route();
      run_play(int'($urandom_range(20, 90)));
      if ($urandom_range(0, 3) == 0) run_play(60);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
